// File: rtl/hex_loader_if.sv
// -----------------------------------------------------------------------------
// hex_loader_if
//   Character-stream handshake between the UART character FIFOs and the hex
//   loader.
//
//   getc side (input FIFO -> loader):
//     getc_en   : FIFO non-empty, getc_char valid
//     getc_char : head of the input FIFO
//     getc_pop  : one-cycle pop pulse from the loader
//   putc side (loader -> output FIFO):
//     putc_en   : output FIFO can accept a character
//     putc_push : one-cycle push pulse from the loader
//     putc_char : character to push, valid while putc_push=1
//
//   master : loader side (drives pop/push)
//   slave  : FIFO side (drives status and head character)
// -----------------------------------------------------------------------------
interface hex_loader_if;
  logic       getc_en;
  logic [7:0] getc_char;
  logic       getc_pop;
  logic       putc_en;
  logic       putc_push;
  logic [7:0] putc_char;

  modport master (
    input  getc_en,
    input  getc_char,
    output getc_pop,
    input  putc_en,
    output putc_push,
    output putc_char
  );

  modport slave (
    output getc_en,
    output getc_char,
    input  getc_pop,
    output putc_en,
    input  putc_push,
    input  putc_char
  );
endinterface

// File: rtl/hex_loader.sv
// -----------------------------------------------------------------------------
// pkg_ram (minimal local copy)
//   RAM store-port types shared with dev_ram: address width, operation code
//   and access size.
// -----------------------------------------------------------------------------
package pkg_ram;
  localparam int RAM_ADDRW = 10;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_LOAD  = 2'd1,
    RAM_STORE = 2'd2
  } ram_op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_HALF = 2'd1,
    RAM_WORD = 2'd2
  } ram_data_type_t;
endpackage

// -----------------------------------------------------------------------------
// hex_loader
//   Text-mode program loader. Reads an ASCII hex stream from the UART input
//   FIFO, packs each pair of hex digits into a byte and stores the bytes at
//   consecutive RAM addresses starting at START_ADDR. Whitespace between
//   bytes is ignored, '#' starts a comment that runs to end of line, and EOT
//   (0x04) finishes the load by echoing "\n" and raising done. Malformed
//   input echoes '?', running out of RAM echoes '!'; both then halt with
//   error set. DONE and ERR hold until reset and leave unread input in the
//   FIFO.
//
// Parameters:
//   RAM_ADDRW  : RAM address width
//   START_ADDR : address of the first stored byte
//
// Ports:
//   clk           : system clock
//   rst           : asynchronous reset, active low
//   io            : getc/putc handshake (master side)
//   ram_op        : RAM_STORE for one cycle per byte, otherwise RAM_NOP
//   ram_data_type : always RAM_BYTE
//   ram_addr      : store address
//   ram_data_in   : store byte
//   byte_count    : bytes stored since reset (never wraps)
//   done          : EOT processed and "\n" pushed (sticky)
//   error         : loader halted on an error (sticky)
// -----------------------------------------------------------------------------
module hex_loader
  import pkg_ram::*;
#(
  parameter int                   RAM_ADDRW  = pkg_ram::RAM_ADDRW,
  parameter logic [RAM_ADDRW-1:0] START_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_loader_if.master         io,
  output ram_op_t              ram_op,
  output ram_data_type_t       ram_data_type,
  output logic [RAM_ADDRW-1:0] ram_addr,
  output logic [7:0]           ram_data_in,
  output logic [RAM_ADDRW:0]   byte_count,
  output logic                 done,
  output logic                 error
);

  // Character codes of interest
  localparam logic [7:0] CH_EOT  = 8'h04;
  localparam logic [7:0] CH_TAB  = 8'h09;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_BANG = 8'h21;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_QM   = 8'h3F;

  // byte_count value at which the RAM is full
  localparam logic [RAM_ADDRW:0] FULL_COUNT = {1'b1, {RAM_ADDRW{1'b0}}};

  typedef enum logic [2:0] {
    ST_HI       = 3'd0,
    ST_LO       = 3'd1,
    ST_CMT      = 3'd2,
    ST_EOT      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR_PUSH = 3'd5,
    ST_ERR      = 3'd6
  } state_t;

  // Returns {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= 8'h30 && c <= 8'h39) begin
      t = c - 8'h30;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      t = c - 8'h57;
      return {1'b1, t[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      t = c - 8'h37;
      return {1'b1, t[3:0]};
    end
    return 5'b0_0000;
  endfunction

  state_t               state_q,      state_d;
  logic [3:0]           nib_q,        nib_d;
  logic [7:0]           diag_q,       diag_d;
  logic                 getc_pop_q,   getc_pop_d;
  logic                 putc_push_q,  putc_push_d;
  logic [7:0]           putc_char_q,  putc_char_d;
  ram_op_t              ram_op_q,     ram_op_d;
  logic [RAM_ADDRW-1:0] ram_addr_q,   ram_addr_d;
  logic [7:0]           ram_data_q,   ram_data_d;
  logic [RAM_ADDRW:0]   byte_count_q, byte_count_d;
  logic                 done_q,       done_d;
  logic                 error_q,      error_d;

  logic [4:0] hex_dec;
  logic       hex_ok;
  logic       is_ws;
  logic       accept;

  assign hex_dec = hex_decode(io.getc_char);
  assign hex_ok  = hex_dec[4];
  assign is_ws   = (io.getc_char == CH_SP)  || (io.getc_char == CH_TAB) ||
                   (io.getc_char == CH_CR)  || (io.getc_char == CH_LF);

  // The pop pulse doubles as the guard: while it is high the FIFO head is
  // still the character just consumed, so it must not be sampled again.
  assign accept = io.getc_en && !getc_pop_q &&
                  ((state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_CMT));

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q;
    diag_d       = diag_q;
    getc_pop_d   = 1'b0;
    putc_push_d  = 1'b0;
    putc_char_d  = putc_char_q;
    ram_op_d     = RAM_NOP;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    byte_count_d = byte_count_q;
    done_d       = done_q;
    error_d      = error_q;

    // The address is held through the store cycle and advanced right after
    // it, which is always before the next byte can complete.
    if (ram_op_q == RAM_STORE) begin
      ram_addr_d = ram_addr_q + 1'b1;
    end

    if (accept) begin
      getc_pop_d = 1'b1;
    end

    case (state_q)
      ST_HI: begin
        if (accept) begin
          if (hex_ok) begin
            nib_d   = hex_dec[3:0];
            state_d = ST_LO;
          end else if (is_ws) begin
            state_d = ST_HI;
          end else if (io.getc_char == CH_HASH) begin
            state_d = ST_CMT;
          end else if (io.getc_char == CH_EOT) begin
            state_d = ST_EOT;
          end else begin
            diag_d  = CH_QM;
            state_d = ST_ERR_PUSH;
          end
        end
      end

      ST_LO: begin
        if (accept) begin
          if (!hex_ok) begin
            diag_d  = CH_QM;
            state_d = ST_ERR_PUSH;
          end else if (byte_count_q == FULL_COUNT) begin
            // RAM already holds 2^RAM_ADDRW bytes: refuse the store so the
            // address never wraps onto already-loaded data.
            diag_d  = CH_BANG;
            state_d = ST_ERR_PUSH;
          end else begin
            ram_op_d     = RAM_STORE;
            ram_data_d   = {nib_q, hex_dec[3:0]};
            byte_count_d = byte_count_q + 1'b1;
            state_d      = ST_HI;
          end
        end
      end

      ST_CMT: begin
        if (accept) begin
          if (io.getc_char == CH_LF) begin
            state_d = ST_HI;
          end else if (io.getc_char == CH_EOT) begin
            state_d = ST_EOT;
          end
        end
      end

      ST_EOT: begin
        if (io.putc_en) begin
          putc_push_d = 1'b1;
          putc_char_d = CH_LF;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_ERR_PUSH: begin
        if (io.putc_en) begin
          putc_push_d = 1'b1;
          putc_char_d = diag_q;
          error_d     = 1'b1;
          state_d     = ST_ERR;
        end
      end

      default: begin
        // ST_DONE / ST_ERR: terminal until reset
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HI;
      nib_q        <= '0;
      diag_q       <= '0;
      getc_pop_q   <= 1'b0;
      putc_push_q  <= 1'b0;
      putc_char_q  <= '0;
      ram_op_q     <= RAM_NOP;
      ram_addr_q   <= START_ADDR;
      ram_data_q   <= '0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_q        <= nib_d;
      diag_q       <= diag_d;
      getc_pop_q   <= getc_pop_d;
      putc_push_q  <= putc_push_d;
      putc_char_q  <= putc_char_d;
      ram_op_q     <= ram_op_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign io.getc_pop    = getc_pop_q;
  assign io.putc_push   = putc_push_q;
  assign io.putc_char   = putc_char_q;
  assign ram_op         = ram_op_q;
  assign ram_data_type  = RAM_BYTE;
  assign ram_addr       = ram_addr_q;
  assign ram_data_in    = ram_data_q;
  assign byte_count     = byte_count_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_hex_loader.sv
module tb_hex_loader;
  import pkg_ram::*;

  localparam int AW_A = pkg_ram::RAM_ADDRW;
  localparam int AW_B = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_loader_if io_a();
  hex_loader_if io_b();

  ram_op_t          op_a, op_b;
  ram_data_type_t   dt_a, dt_b;
  logic [AW_A-1:0]  addr_a;
  logic [AW_B-1:0]  addr_b;
  logic [7:0]       data_a, data_b;
  logic [AW_A:0]    bc_a;
  logic [AW_B:0]    bc_b;
  logic             done_a, done_b, error_a, error_b;

  hex_loader dut_a (
    .clk(clk), .rst(rst_n), .io(io_a.master),
    .ram_op(op_a), .ram_data_type(dt_a), .ram_addr(addr_a),
    .ram_data_in(data_a), .byte_count(bc_a), .done(done_a), .error(error_a)
  );

  hex_loader #(.RAM_ADDRW(AW_B), .START_ADDR(2'd1)) dut_b (
    .clk(clk), .rst(rst_n), .io(io_b.master),
    .ram_op(op_b), .ram_data_type(dt_b), .ram_addr(addr_b),
    .ram_data_in(data_b), .byte_count(bc_b), .done(done_b), .error(error_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  byte  fifo_a[$], fifo_b[$];
  st_t  exp_st_a[$], exp_st_b[$];
  byte  exp_pc_a[$], exp_pc_b[$];
  int   pops_a = 0, pops_b = 0, pushes_a = 0, pushes_b = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO model + scoreboard for dut_a (all sampling on the falling edge)
  initial begin
    logic prev_pop, prev_st;
    st_t  st;
    byte  e;
    prev_pop = 1'b0;
    prev_st  = 1'b0;
    io_a.getc_en   = 1'b0;
    io_a.getc_char = 8'h00;
    forever begin
      @(negedge clk);
      if (io_a.getc_pop) begin
        check_eq("a_pop_gap", 32'(prev_pop), 32'd0);
        if (fifo_a.size() != 0) void'(fifo_a.pop_front());
        pops_a++;
      end
      prev_pop = io_a.getc_pop;
      if (op_a == RAM_STORE) begin
        check_eq("a_store_1cyc", 32'(prev_st), 32'd0);
        $display("[%0t] a store addr=%0h data=%02h", $time, addr_a, data_a);
        if (exp_st_a.size() == 0) begin
          check_eq("a_store_unexpected", 32'd1, 32'd0);
        end else begin
          st = exp_st_a.pop_front();
          check_eq("a_store_addr", 32'(addr_a), 32'(st.addr));
          check_eq("a_store_data", 32'(data_a), 32'(st.data));
        end
      end
      prev_st = (op_a == RAM_STORE);
      if (io_a.putc_push) begin
        pushes_a++;
        $display("[%0t] a push char=%02h", $time, io_a.putc_char);
        if (exp_pc_a.size() == 0) begin
          check_eq("a_push_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_pc_a.pop_front();
          check_eq("a_push_char", 32'(io_a.putc_char), 32'(e));
          check_eq("a_push_flag", 32'((e == 8'h0A) ? done_a : error_a), 32'd1);
        end
      end
      io_a.getc_en   = (fifo_a.size() != 0);
      io_a.getc_char = (fifo_a.size() != 0) ? fifo_a[0] : 8'h00;
    end
  end

  // FIFO model + scoreboard for dut_b
  initial begin
    logic prev_pop, prev_st;
    st_t  st;
    byte  e;
    prev_pop = 1'b0;
    prev_st  = 1'b0;
    io_b.getc_en   = 1'b0;
    io_b.getc_char = 8'h00;
    forever begin
      @(negedge clk);
      if (io_b.getc_pop) begin
        check_eq("b_pop_gap", 32'(prev_pop), 32'd0);
        if (fifo_b.size() != 0) void'(fifo_b.pop_front());
        pops_b++;
      end
      prev_pop = io_b.getc_pop;
      if (op_b == RAM_STORE) begin
        check_eq("b_store_1cyc", 32'(prev_st), 32'd0);
        $display("[%0t] b store addr=%0h data=%02h", $time, addr_b, data_b);
        if (exp_st_b.size() == 0) begin
          check_eq("b_store_unexpected", 32'd1, 32'd0);
        end else begin
          st = exp_st_b.pop_front();
          check_eq("b_store_addr", 32'(addr_b), 32'(st.addr));
          check_eq("b_store_data", 32'(data_b), 32'(st.data));
        end
      end
      prev_st = (op_b == RAM_STORE);
      if (io_b.putc_push) begin
        pushes_b++;
        $display("[%0t] b push char=%02h", $time, io_b.putc_char);
        if (exp_pc_b.size() == 0) begin
          check_eq("b_push_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_pc_b.pop_front();
          check_eq("b_push_char", 32'(io_b.putc_char), 32'(e));
          check_eq("b_push_flag", 32'((e == 8'h0A) ? done_b : error_b), 32'd1);
        end
      end
      io_b.getc_en   = (fifo_b.size() != 0);
      io_b.getc_char = (fifo_b.size() != 0) ? fifo_b[0] : 8'h00;
    end
  end

  task automatic exp_store_a(input int addr, input logic [7:0] d);
    st_t s;
    s.addr = 16'(addr);
    s.data = d;
    exp_st_a.push_back(s);
  endtask

  task automatic exp_store_b(input int addr, input logic [7:0] d);
    st_t s;
    s.addr = 16'(addr);
    s.data = d;
    exp_st_b.push_back(s);
  endtask

  task automatic send_a(input string s);
    @(posedge clk); #1;
    for (int i = 0; i < s.len(); i++) fifo_a.push_back(s[i]);
  endtask

  task automatic send_b(input string s);
    @(posedge clk); #1;
    for (int i = 0; i < s.len(); i++) fifo_b.push_back(s[i]);
  endtask

  task automatic chk_reset_vals();
    check_eq("rst_a_pop",   32'(io_a.getc_pop),  32'd0);
    check_eq("rst_a_push",  32'(io_a.putc_push), 32'd0);
    check_eq("rst_a_pchar", 32'(io_a.putc_char), 32'd0);
    check_eq("rst_a_op",    32'(op_a),   32'(RAM_NOP));
    check_eq("rst_a_dtype", 32'(dt_a),   32'(RAM_BYTE));
    check_eq("rst_a_addr",  32'(addr_a), 32'd0);
    check_eq("rst_a_data",  32'(data_a), 32'd0);
    check_eq("rst_a_count", 32'(bc_a),   32'd0);
    check_eq("rst_a_done",  32'(done_a), 32'd0);
    check_eq("rst_a_error", 32'(error_a), 32'd0);
    check_eq("rst_b_addr",  32'(addr_b), 32'd1);
    check_eq("rst_b_count", 32'(bc_b),   32'd0);
    check_eq("rst_b_op",    32'(op_b),   32'(RAM_NOP));
    check_eq("rst_b_error", 32'(error_b), 32'd0);
  endtask

  // Reset asserted a few ns after a falling edge, well away from any
  // rising edge, so the checks see the asynchronous response.
  task automatic do_reset(input bit check_now);
    @(negedge clk); #2;
    rst_n = 1'b0;
    fifo_a.delete();
    fifo_b.delete();
    #1;
    if (check_now) chk_reset_vals();
    pops_a = 0; pops_b = 0; pushes_a = 0; pushes_b = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic flag_sel(input int which);
    case (which)
      0:       return done_a;
      1:       return error_a;
      default: return error_b;
    endcase
  endfunction

  task automatic wait_flag(input string tag, input int which, input int budget);
    int n;
    n = 0;
    while (!flag_sel(which) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(flag_sel(which)), 32'd1);
  endtask

  task automatic wait_pops_a(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (pops_a < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(pops_a), 32'(target));
  endtask

  task automatic sb_empty(input string tag);
    check_eq(tag, 32'(exp_st_a.size() + exp_pc_a.size() + exp_st_b.size() + exp_pc_b.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    io_a.putc_en = 1'b1;
    io_b.putc_en = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;

    // Basic stream with whitespace between bytes
    exp_store_a(0, 8'h12); exp_store_a(1, 8'hAB); exp_store_a(2, 8'hFF);
    exp_pc_a.push_back(8'h0A);
    send_a("12 ab\nFF\004");
    wait_flag("t1_done", 0, 200);
    repeat (3) @(negedge clk);
    check_eq("t1_count", 32'(bc_a), 32'd3);
    check_eq("t1_pops",  32'(pops_a), 32'd9);
    check_eq("t1_error", 32'(error_a), 32'd0);
    sb_empty("t1_sb_empty");

    // Comment line is consumed without stores
    do_reset(1'b0);
    exp_store_a(0, 8'h7E);
    exp_pc_a.push_back(8'h0A);
    send_a("# hi\n7e\004");
    wait_flag("t2_done", 0, 200);
    repeat (3) @(negedge clk);
    check_eq("t2_count", 32'(bc_a), 32'd1);
    check_eq("t2_pops",  32'(pops_a), 32'd8);
    sb_empty("t2_sb_empty");

    // Whitespace in the middle of a byte is malformed
    do_reset(1'b0);
    exp_pc_a.push_back(8'h3F);
    send_a("1 2");
    wait_flag("t3_error", 1, 200);
    repeat (10) @(negedge clk);
    check_eq("t3_pops",  32'(pops_a), 32'd2);
    check_eq("t3_left",  32'(fifo_a.size()), 32'd1);
    check_eq("t3_count", 32'(bc_a), 32'd0);
    check_eq("t3_done",  32'(done_a), 32'd0);
    sb_empty("t3_sb_empty");

    // EOT echo waits for output FIFO space
    do_reset(1'b0);
    io_a.putc_en = 1'b0;
    exp_store_a(0, 8'h5A);
    send_a("5a\004");
    repeat (30) @(negedge clk);
    check_eq("t4_no_push", 32'(pushes_a), 32'd0);
    check_eq("t4_no_done", 32'(done_a), 32'd0);
    check_eq("t4_count",   32'(bc_a), 32'd1);
    exp_pc_a.push_back(8'h0A);
    io_a.putc_en = 1'b1;
    wait_flag("t4_done", 0, 50);
    repeat (5) @(negedge clk);
    check_eq("t4_one_push", 32'(pushes_a), 32'd1);
    check_eq("t4_sticky",   32'(done_a), 32'd1);
    sb_empty("t4_sb_empty");

    // Overflow on a 4-byte RAM starting at address 1 (address wraps)
    do_reset(1'b0);
    exp_store_b(1, 8'h00); exp_store_b(2, 8'h11);
    exp_store_b(3, 8'h22); exp_store_b(0, 8'h33);
    exp_pc_b.push_back(8'h21);
    send_b("00 11 22 33 44");
    wait_flag("t5_error", 2, 400);
    repeat (5) @(negedge clk);
    check_eq("t5_count", 32'(bc_b), 32'd4);
    check_eq("t5_pops",  32'(pops_b), 32'd14);
    check_eq("t5_done",  32'(done_b), 32'd0);
    sb_empty("t5_sb_empty");

    // Reset mid-byte, then a fresh stream starts over at START_ADDR
    do_reset(1'b0);
    exp_store_a(0, 8'h77);
    send_a("77 3");
    wait_pops_a("t6_pops", 4, 100);
    repeat (2) @(negedge clk);
    check_eq("t6_count_pre", 32'(bc_a), 32'd1);
    check_eq("t6_addr_pre",  32'(addr_a), 32'd1);
    do_reset(1'b1);
    exp_store_a(0, 8'hC4);
    exp_pc_a.push_back(8'h0A);
    send_a("c4\004");
    wait_flag("t6_done", 0, 200);
    repeat (3) @(negedge clk);
    check_eq("t6_count", 32'(bc_a), 32'd1);
    sb_empty("t6_sb_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_loader.md
# hex_loader

Text-mode program loader between the UART character FIFO (`dev_io` getc/putc side) and the byte-wide store port of `dev_ram`. It consumes an ASCII hex stream from the host, packs each pair of hex digits into one byte and stores it at consecutive RAM addresses. On EOT (0x04) it echoes `"\n"` and raises `done`; on malformed input or RAM overflow it echoes a diagnostic character and halts. It replaces the raw-binary loader loop in the board top level.

## Interface
- `RAM_ADDRW`, default `pkg_ram::RAM_ADDRW`: RAM address width.
- `START_ADDR`, default 0: first store address.
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-low.
- `getc_en` in 1: input FIFO non-empty; `getc_char` is valid.
- `getc_char` in 8: head of the input FIFO.
- `getc_pop` out 1: one-cycle pop pulse.
- `putc_en` in 1: output FIFO can accept a character.
- `putc_push` out 1: one-cycle push pulse.
- `putc_char` out 8: character to push; valid while `putc_push`=1.
- `ram_op` out `pkg_ram` op type: `RAM_STORE` for one cycle per byte, otherwise `RAM_NOP`. `ram_data_type` is tied to `RAM_BYTE`.
- `ram_addr` out `RAM_ADDRW`: store address.
- `ram_data_in` out 8: store byte.
- `byte_count` out `RAM_ADDRW+1`: number of bytes stored since reset.
- `done` out 1: EOT processed and `"\n"` pushed; sticky.
- `error` out 1: loader halted on an error; sticky.

## Operation
- FSM states: HI (await high nibble), LO (await low nibble), CMT (comment), EOT (push `"\n"`), DONE, ERR_PUSH (push diagnostic), ERR.
- Character acceptance:
  - A character is accepted in a cycle where `getc_en`=1, the FSM is in HI, LO or CMT, and the pop guard is clear.
  - Every accepted character is popped exactly once.
- Hex digits are `0-9`, `a-f` and `A-F`.
- HI state:
  - Hex digit: latch it as the high nibble, go to LO.
  - Space, `\t`, `\r` or `\n`: pop and ignore.
  - `#`: go to CMT.
  - 0x04: go to EOT.
  - Any other character: diagnostic `?`, go to ERR_PUSH.
- LO state:
  - Hex digit: form the byte and issue a store, go to HI.
  - Any other character, including whitespace or 0x04: diagnostic `?`, go to ERR_PUSH.
- CMT state:
  - Discard all characters.
  - `\n`: go to HI.
  - 0x04: go to EOT.
- Overflow: if a byte completes while `byte_count` = 2^RAM_ADDRW, no store is issued; diagnostic `!`, go to ERR_PUSH.
- EOT state: wait for `putc_en`=1, push `"\n"`, go to DONE.
- ERR_PUSH state: wait for `putc_en`=1, push the latched diagnostic, go to ERR.
- DONE and ERR are terminal until reset. In these states there are no pops and no stores, and unread input remains in the FIFO.
- Address arithmetic:
  - `ram_addr` advances by 1 modulo 2^RAM_ADDRW after each store.
  - `byte_count` increments per store and never wraps; overflow is caught before it can wrap.

## Timing
- Reset values: `getc_pop`=0, `putc_push`=0, `putc_char`=0, `ram_op`=`RAM_NOP`, `ram_addr`=`START_ADDR`, `ram_data_in`=0, `byte_count`=0, `done`=0, `error`=0, state HI.
- All outputs are registered.
- Character accept and pop:
  - A character sampled at edge t gives `getc_pop`=1 during cycle t+1.
  - The pop guard blocks acceptance in cycle t+1, so the FIFO can update and no character is double-read.
  - Maximum rate is one character per 2 cycles.
- Store:
  - The low nibble sampled at t gives `ram_op`=`RAM_STORE` with the final `ram_addr`/`ram_data_in` during cycle t+1 (same cycle as the pop).
  - `byte_count` is updated at t+1.
  - `ram_op` returns to `RAM_NOP` at t+2.
  - Store address for byte k (0-based) is `START_ADDR`+k.
- Push: `putc_push` is high for exactly one cycle, the cycle after `putc_en` is sampled high in EOT or ERR_PUSH.
- Flags:
  - `done` rises in the same cycle as the `"\n"` push.
  - `error` rises in the same cycle as the diagnostic push.
- Reset asserted mid-operation:
  - Immediate return to the reset values.
  - A partial nibble is discarded.
  - Any pending push is dropped.

## Test plan
- Stream `"12 ab\nFF"` then 0x04 -> stores at addr 0/1/2 of 0x12/0xAB/0xFF, each `ram_op` pulse 1 cycle; `byte_count`=3; `"\n"` pushed; `done`=1; exactly 9 pops.
- Stream `"# hi\n7e"` then 0x04 -> single store of 0x7E at `START_ADDR`; comment bytes popped but not stored.
- Stream `"1 2"` -> after `"1"`, the space triggers `?` push and `error`=1; no stores; subsequent FIFO bytes are not popped.
- With `putc_en`=0 held for 20 cycles after EOT -> no push until `putc_en`=1, then one `"\n"` push and `done`=1.
- With `RAM_ADDRW`=2, send 5 bytes -> 4 stores at addr 0..3, fifth byte pushes `!`, `error`=1, `byte_count`=4.
- `getc_en` held high continuously -> pops never in consecutive cycles. Assert `rst` low mid-byte -> outputs return to reset values asynchronously; the next stream stores from `START_ADDR`.
